// File: rtl/ram_1port_be.sv
// Single-port byte-enabled RAM with zero-fill init and an in-order read-return FIFO.
// Optional per-byte even parity when RAM_1PORT_BE_PARITY_EN is defined.
module ram_1port_be #(
  parameter int Width    = 64,
  parameter int Size     = 128,
  parameter int OutDepth = 2,
  parameter int InitZero = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_retry,
  input  logic                     req_we,
  input  logic [$clog2(Size)-1:0]  req_pos,
  input  logic [Width/8-1:0]       req_be,
  input  logic [Width-1:0]         req_data,
  output logic                     ack_valid,
  input  logic                     ack_retry,
  output logic [Width-1:0]         ack_data,
  output logic                     ack_perr,
  output logic                     init_done
);
  localparam int AW = $clog2(Size);
  localparam int NB = Width / 8;
  localparam int PW = (OutDepth > 1) ? $clog2(OutDepth) : 1;
  localparam int CW = $clog2(OutDepth + 1);
  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;
  localparam logic ST_RST  = (InitZero != 0) ? ST_INIT : ST_RUN;

  logic          state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic          full, acc, wr_acc, push, pop, init_we;

  logic [Width-1:0] mem_q  [Size];
  logic [Width-1:0] fifo_q [OutDepth];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OutDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == AW'(Size - 1)) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RST;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Retry looks only at occupancy, never at ack_retry, so a same-edge pop does not unblock a read.
  assign full      = (cnt_q == CW'(OutDepth));
  assign req_retry = (state_q == ST_INIT) | (!req_we & full);
  assign acc       = req_valid & !req_retry;
  assign wr_acc    = acc & req_we;
  assign push      = acc & !req_we;
  assign pop       = ack_valid & !ack_retry;
  assign init_we   = (state_q == ST_INIT);
  assign init_done = (state_q == ST_RUN) & reset;

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[init_cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++)
        if (req_be[b]) mem_q[req_pos][8*b +: 8] <= req_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= mem_q[req_pos];
  end

  assign ack_valid = (cnt_q != '0);
  assign ack_data  = ack_valid ? fifo_q[rptr_q] : '0;

`ifdef RAM_1PORT_BE_PARITY_EN
  logic [NB-1:0] par_q   [Size];
  logic          fperr_q [OutDepth];
  logic [NB-1:0] rd_par;
  logic          rd_perr;

  always_ff @(posedge clk) begin
    if (init_we) begin
      par_q[init_cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++)
        if (req_be[b]) par_q[req_pos][b] <= ^req_data[8*b +: 8];
    end
  end

  always_comb begin
    rd_par = '0;
    for (int b = 0; b < NB; b++) rd_par[b] = ^mem_q[req_pos][8*b +: 8];
  end
  assign rd_perr = |(rd_par ^ par_q[req_pos]);

  always_ff @(posedge clk) begin
    if (push) fperr_q[wptr_q] <= rd_perr;
  end

  assign ack_perr = ack_valid ? fperr_q[rptr_q] : 1'b0;
`else
  assign ack_perr = 1'b0;
`endif

endmodule

// File: doc/ram_1port_be.md
RAM_1PORT_BE -- requirements
Module: ram_1port_be

Interface
REQ-001 SHALL have parameter Width, default 64, data width in bits; multiple of 8.
REQ-002 SHALL have parameter Size, default 128, number of words; 16..256, power of 2.
REQ-003 SHALL have parameter OutDepth, default 2, read-return buffer entries; 1..4.
REQ-004 SHALL have parameter InitZero, default 1, zero-fill memory after reset when 1.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_retry  out  1  request not accepted this cycle.
REQ-009 req_we  in  1  1=write, 0=read.
REQ-010 req_pos  in  log2(Size)  word address.
REQ-011 req_be  in  Width/8  byte enables, writes only.
REQ-012 req_data  in  Width  write data.
REQ-013 ack_valid  out  1  read data present.
REQ-014 ack_retry  in  1  consumer stall.
REQ-015 ack_data  out  Width  read data.
REQ-016 ack_perr  out  1  parity error flag for ack_data.
REQ-017 init_done  out  1  1 once memory usable.

Function
REQ-018 Request SHALL be accepted on a rising edge with req_valid=1 and req_retry=0; ack SHALL be consumed on an edge with ack_valid=1 and ack_retry=0.
REQ-019 States INIT, RUN; INIT SHALL write zero to pos 0..Size-1, one per cycle, then go to RUN (exactly Size cycles); InitZero=0 SHALL enter RUN directly.
REQ-020 In INIT: req_retry=1, init_done=0; in RUN: init_done=1.
REQ-021 Accepted write SHALL update only bytes with req_be[i]=1; others unchanged; writes produce no ack.
REQ-022 req_retry SHALL be 1 in INIT, else (req_we=0 and buffer occupancy==OutDepth), else 0; writes never stalled by the buffer.
REQ-023 req_retry SHALL NOT depend combinationally on ack_retry.
REQ-024 Accepted read SHALL push word into the FIFO return buffer; ack_valid SHALL assert the cycle after acceptance when buffer was empty (1-cycle latency).
REQ-025 Read data SHALL reflect all writes accepted in earlier cycles.
REQ-026 Acks SHALL return in request order; ack_data/ack_perr SHALL hold stable while ack_valid=1 and ack_retry=1.
REQ-027 Same-edge push and pop SHALL leave occupancy unchanged; occupancy SHALL never exceed OutDepth or underflow.
REQ-028 req_pos is in range by construction (Size power of 2); no wrap handling required.

Reset
REQ-029 reset=0 SHALL immediately force ack_valid=0, occupancy=0, init_done=0, ack_perr=0, ack_data=0, init counter=0.
REQ-030 On release, state SHALL be INIT (InitZero=1) or RUN (InitZero=0); reset mid-INIT or mid-stream SHALL drop queued acks and restart INIT from pos 0.
REQ-031 With InitZero=0, memory contents after reset are undefined.

Configuration
REQ-032 Macro RAM_1PORT_BE_PARITY_EN defined: one even-parity bit stored per byte, updated on byte write (incl. INIT); on read recomputed, ack_perr=1 if any enabled-byte mismatch, carried through the buffer with its data.
REQ-033 Macro undefined: no parity storage; ack_perr SHALL be constant 0; port list unchanged.

Verification (Width=32, Size=16, OutDepth=2, InitZero=1)
REQ-034 Release reset -> req_retry=1 for 16 cycles, init_done=1 on cycle 16; read pos 5 -> ack_data=0x00000000, ack_perr=0.
REQ-035 Write pos 3 0xAABBCCDD be=4'b1111, write pos 3 0x11223344 be=4'b0101, read pos 3 -> ack_data=0xAA22CC44 one cycle after read acceptance.
REQ-036 ack_retry=1, three reads pos 1,2,3 -> two accepted, req_retry=1 on third; write pos 7 accepted meanwhile; ack_retry=0 -> data pos1, pos2, then third read accepted and returned.
REQ-037 Read/write/read pos 9 back-to-back (write 0x5A5A5A5A) -> first ack old value, second ack 0x5A5A5A5A.
REQ-038 Two acks queued, assert reset mid-cycle -> ack_valid=0 immediately; after release INIT repeats, both acks never appear.
REQ-039 With RAM_1PORT_BE_PARITY_EN, backdoor flip data bit 0 at pos 4, read pos 4 -> ack_perr=1; without macro -> ack_perr=0.
